// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder (MSB first, 8-bit frames) for the j1 IO bus.
// SPI pins are oversampled by clk; the CPU side mirrors the UART: strobes plus flags.
module spi_target #(
  parameter int unsigned RX_DEPTH    = 4,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_ssb,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  input  logic       wr,
  input  logic [7:0] tx_data,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       tx_ready,
  output logic       overrun,
  input  logic       clr_ovr,
  output logic       ss_active
);
  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ssb_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;

  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_shift_rx;
  logic [7:0]       r_shift_tx;
  logic [7:0]       r_tx_hold;
  logic             r_tx_full;
  logic [7:0]       r_mem [RX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overrun;

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_ssb_rise;
  logic       w_ssb_fall;
  logic       w_sdi;
  logic       w_load;
  logic       w_shift_tx;
  logic       w_sample;
  logic       w_push;
  logic       w_abort;
  logic [7:0] w_rx_byte;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_fifo_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_ssb_sync <= '1;
      r_sdi_sync <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_ssb_sync <= {r_ssb_sync[SYNC_STAGES-2:0], spi_ssb};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
    end
  end

  // Edges compare the last two stages; sdi is taken from the oldest stage,
  // which is stable because the master holds it for several clk around sck edges.
  assign w_sck_rise = r_sck_sync[SYNC_STAGES-2] & ~r_sck_sync[SYNC_STAGES-1];
  assign w_sck_fall = ~r_sck_sync[SYNC_STAGES-2] & r_sck_sync[SYNC_STAGES-1];
  assign w_ssb_rise = r_ssb_sync[SYNC_STAGES-2] & ~r_ssb_sync[SYNC_STAGES-1];
  assign w_ssb_fall = ~r_ssb_sync[SYNC_STAGES-2] & r_ssb_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift_tx   = 1'b0;
    w_sample     = 1'b0;
    w_push       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ssb_fall) begin
          w_state_next = ST_ACTIVE;
          w_load       = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A deselect in the same cycle masks any sck edge.
        if (w_ssb_rise) begin
          w_state_next = ST_IDLE;
          w_abort      = 1'b1;
        end else if (w_sck_rise) begin
          w_sample = 1'b1;
          w_push   = (r_bit_cnt == 3'd7);
        end else if (w_sck_fall) begin
          if (r_bit_cnt == 3'd0) begin
            w_load = 1'b1;
          end else begin
            w_shift_tx = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_rx_byte = {r_shift_rx, w_sdi};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= 3'd0;
      r_shift_rx <= 7'd0;
      r_shift_tx <= IDLE_BYTE;
      r_tx_hold  <= 8'd0;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_abort) begin
        r_bit_cnt  <= 3'd0;
        r_shift_rx <= 7'd0;
      end else if (w_sample) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_shift_rx <= {r_shift_rx[5:0], w_sdi};
      end
      if (w_load) begin
        r_shift_tx <= r_tx_full ? r_tx_hold : IDLE_BYTE;
      end else if (w_shift_tx) begin
        r_shift_tx <= {r_shift_tx[6:0], 1'b0};
      end
      // A load sees the old holding state; a write into an empty register
      // still lands even when that load just used IDLE_BYTE.
      if (wr && !r_tx_full) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_load) begin
        r_tx_full <= 1'b0;
      end
    end
  end

  assign w_full    = (r_count == CNT_W'(RX_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = rd && !w_empty;
  assign w_fifo_wr = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= w_rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_fifo_wr && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_fifo_wr) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_push && !w_fifo_wr) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign spi_sdo    = r_shift_tx[7];
  assign spi_sdo_oe = (r_state == ST_ACTIVE);
  assign ss_active  = (r_state == ST_ACTIVE);
  assign valid      = !w_empty;
  assign rx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign tx_ready   = !r_tx_full;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed bench for spi_target; a transaction-level model of the
// rx FIFO, tx holding register and overrun flag is compared against the DUT each idle cycle.
`timescale 1ns/1ps
module tb_spi_target;
  localparam int RX_DEPTH = 4;
  localparam int SYNC     = 3;
  localparam int HALF     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_ssb = 1'b1;
  logic       spi_sdi = 1'b0;
  logic       spi_sdo;
  logic       spi_sdo_oe;
  logic       wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rd = 1'b0;
  logic [7:0] rx_data;
  logic       valid;
  logic       tx_ready;
  logic       overrun;
  logic       clr_ovr = 1'b0;
  logic       ss_active;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       model_tx_full = 1'b0;
  logic [7:0] model_tx_byte = 8'h00;
  logic       model_ovr = 1'b0;
  logic       chk_en = 1'b0;
  logic [7:0] exp_rx;
  logic [7:0] mosi_buf [8];
  logic [7:0] miso_buf [8];

  always #5 clk = ~clk;

  spi_target #(
    .RX_DEPTH(RX_DEPTH),
    .IDLE_BYTE(8'hFF),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_sck(spi_sck),
    .spi_ssb(spi_ssb),
    .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo),
    .spi_sdo_oe(spi_sdo_oe),
    .wr(wr),
    .tx_data(tx_data),
    .rd(rd),
    .rx_data(rx_data),
    .valid(valid),
    .tx_ready(tx_ready),
    .overrun(overrun),
    .clr_ovr(clr_ovr),
    .ss_active(ss_active)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b time=%0t", name, act, exp, $time);
    end
  endtask

  // Model: byte the DUT must shift out at a frame boundary, consuming the holding register.
  function automatic logic [7:0] model_take();
    logic [7:0] b;
    b = model_tx_full ? model_tx_byte : 8'hFF;
    model_tx_full = 1'b0;
    return b;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() < RX_DEPTH) exp_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    model_tx_full = 1'b0;
    model_tx_byte = 8'h00;
    model_ovr     = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      exp_rx = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
      check1("valid", valid, exp_q.size() != 0);
      check8("rx_data", rx_data, exp_rx);
      check1("tx_ready", tx_ready, !model_tx_full);
      check1("overrun", overrun, model_ovr);
      check1("sdo_oe_idle", spi_sdo_oe, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] b);
    wr = 1'b1;
    tx_data = b;
    tick(1);
    wr = 1'b0;
    if (!model_tx_full) begin
      model_tx_full = 1'b1;
      model_tx_byte = b;
    end
  endtask

  task automatic cpu_read();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic cpu_clr_ovr();
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    model_ovr = 1'b0;
  endtask

  task automatic spi_select();
    chk_en = 1'b0;
    spi_ssb = 1'b0;
    tick(HALF);
  endtask

  task automatic spi_deselect();
    tick(HALF);
    spi_ssb = 1'b1;
    tick(HALF);
    chk_en = 1'b1;
  endtask

  // Mode 0 master: data changes while sck is low, MISO captured on the rising edge.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, input bit rd_hit,
                          output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_sdi = mosi[i];
      tick(HALF);
      spi_sck = 1'b1;
      miso[i] = spi_sdo;
      for (int c = 1; c <= HALF; c++) begin
        tick(1);
        if (rd_hit && i == 0 && c == SYNC - 1) rd = 1'b1;
        if (rd_hit && i == 0 && c == SYNC) rd = 1'b0;
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input int n, input bit rd_hit_last);
    logic [7:0] exp_miso;
    logic [7:0] got;
    spi_select();
    exp_miso = model_take();
    for (int k = 0; k < n; k++) begin
      spi_bits(mosi_buf[k], 8, rd_hit_last && (k == n - 1), got);
      miso_buf[k] = got;
      check8($sformatf("miso_byte%0d", k), got, exp_miso);
      if (rd_hit_last && k == n - 1 && exp_q.size() != 0) void'(exp_q.pop_front());
      model_push(mosi_buf[k]);
      exp_miso = model_take();
    end
    spi_deselect();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dummy;
    model_reset();
    // Reset with idle pins.
    tick(2);
    check1("rst_sdo_oe", spi_sdo_oe, 1'b0);
    check1("rst_sdo", spi_sdo, 1'b1);
    check1("rst_valid", valid, 1'b0);
    check1("rst_tx_ready", tx_ready, 1'b1);
    check1("rst_overrun", overrun, 1'b0);
    check8("rst_rx_data", rx_data, 8'h00);
    check1("rst_ss_active", ss_active, 1'b0);
    reset = 1'b0;
    tick(2);
    chk_en = 1'b1;

    // Single byte exchange.
    cpu_write(8'hA5);
    check1("single_tx_ready_low", tx_ready, 1'b0);
    mosi_buf[0] = 8'h3C;
    spi_frame(1, 1'b0);
    check8("single_miso", miso_buf[0], 8'hA5);
    check1("single_valid", valid, 1'b1);
    check8("single_rx", rx_data, 8'h3C);
    check1("single_tx_ready", tx_ready, 1'b1);
    cpu_read();
    check1("single_valid_after_rd", valid, 1'b0);

    // Two bytes with nothing pending on tx.
    mosi_buf[0] = 8'h01;
    mosi_buf[1] = 8'h02;
    spi_frame(2, 1'b0);
    check8("idle_miso0", miso_buf[0], 8'hFF);
    check8("idle_miso1", miso_buf[1], 8'hFF);
    check8("idle_rx0", rx_data, 8'h01);
    cpu_read();
    check8("idle_rx1", rx_data, 8'h02);
    cpu_read();
    check1("idle_empty", valid, 1'b0);

    // Overflow: five bytes into a four-deep FIFO.
    for (int k = 0; k < 5; k++) mosi_buf[k] = 8'h10 + 8'(k);
    spi_frame(5, 1'b0);
    check8("ovf_head", rx_data, 8'h10);
    check1("ovf_overrun", overrun, 1'b1);
    cpu_clr_ovr();
    check1("ovf_cleared", overrun, 1'b0);
    mosi_buf[0] = 8'h15;
    spi_frame(1, 1'b1);
    check1("ovf_rd_push_no_ovr", overrun, 1'b0);
    check8("ovf_drain0", rx_data, 8'h11);
    cpu_read();
    check8("ovf_drain1", rx_data, 8'h12);
    cpu_read();
    check8("ovf_drain2", rx_data, 8'h13);
    cpu_read();
    check8("ovf_drain3", rx_data, 8'h15);
    cpu_read();
    check1("ovf_empty", valid, 1'b0);

    // Aborted frame after 5 bits, then a full frame.
    spi_select();
    void'(model_take());
    spi_bits(8'hAB, 5, 1'b0, dummy);
    spi_deselect();
    check1("abort_nothing", valid, 1'b0);
    mosi_buf[0] = 8'hC3;
    spi_frame(1, 1'b0);
    check8("abort_rx", rx_data, 8'hC3);
    cpu_read();
    check1("abort_count1", valid, 1'b0);

    // Holding register: second write while full is ignored.
    cpu_write(8'h55);
    cpu_write(8'hAA);
    check1("hold_not_ready", tx_ready, 1'b0);
    mosi_buf[0] = 8'h77;
    spi_frame(1, 1'b0);
    check8("hold_miso", miso_buf[0], 8'h55);
    mosi_buf[0] = 8'h78;
    spi_frame(1, 1'b0);
    check8("hold_aa_not_sent", miso_buf[0], 8'hFF);
    check1("hold_fifo_valid", valid, 1'b1);

    // Reset in the middle of a byte.
    spi_select();
    void'(model_take());
    spi_bits(8'h96, 4, 1'b0, dummy);
    check1("midrst_oe_before", spi_sdo_oe, 1'b1);
    reset = 1'b1;
    spi_ssb = 1'b1;
    spi_sck = 1'b0;
    tick(1);
    check1("midrst_oe", spi_sdo_oe, 1'b0);
    check1("midrst_valid", valid, 1'b0);
    check8("midrst_rx", rx_data, 8'h00);
    check1("midrst_tx_ready", tx_ready, 1'b1);
    reset = 1'b0;
    model_reset();
    tick(HALF);
    chk_en = 1'b1;
    tick(HALF);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
